// File: rtl/tft_timing_pkg.sv
// ---------------------------------------------------------------------------
// tft_timing_pkg
//   Shared raster constants for the 800x480 TFT-LCD path. The LCD control and
//   BRAM address stages import the same values, so everyone agrees on where
//   the visible window sits inside the line and the frame.
//   Contents: default H/V active, porch and sync widths, totals, the default
//   counter width, the sync-polarity encoding and a width-check helper.
// ---------------------------------------------------------------------------
package tft_timing_pkg;

   // Horizontal timing, in pixels
   localparam int H_ACTIVE = 800;
   localparam int H_FP     = 40;
   localparam int H_SYNC   = 48;
   localparam int H_BP     = 40;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 928

   // Vertical timing, in lines
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 13;
   localparam int V_SYNC   = 3;
   localparam int V_BP     = 32;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 528

   // Default counter width; holds H_TOTAL-1 and V_TOTAL-1
   localparam int TFT_CNT_W = 10;

   // Sync polarity encoding: the level the sync pin takes while asserted
   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   // True when a cnt_w-bit counter can represent every index 0..total-1
   function automatic bit total_fits(input int total, input int cnt_w);
      return total <= (1 << cnt_w);
   endfunction

endpackage

// File: rtl/tft_sync_axis.sv
// ---------------------------------------------------------------------------
// tft_sync_axis
//   One raster axis (horizontal in pixels, or vertical in lines). Keeps the
//   position counter and registers the active-region and sync-region flags
//   decoded from the next count, so the flags line up with count.
//   Ports:
//     CLK    in   clock
//     RESET  in   synchronous active-high reset
//     step   in   advance one position this cycle
//     count  out  current position, 0..TOTAL-1
//     wrap   out  the next step lands on position 0
//     de     out  count is in the active region
//     sync   out  count is in the sync region (raw, active-high)
// ---------------------------------------------------------------------------
module tft_sync_axis #(
   parameter int ACTIVE = tft_timing_pkg::H_ACTIVE,
   parameter int FP     = tft_timing_pkg::H_FP,
   parameter int SYNC   = tft_timing_pkg::H_SYNC,
   parameter int BP     = tft_timing_pkg::H_BP,
   parameter int CNT_W  = tft_timing_pkg::TFT_CNT_W
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             step,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic             de,
   output logic             sync
);
   import tft_timing_pkg::*;

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);

   if (!total_fits(TOTAL, CNT_W)) begin : g_err_width
      $error("tft_sync_axis: TOTAL=%0d does not fit in CNT_W=%0d bits", TOTAL, CNT_W);
   end
   if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_err_zero
      $error("tft_sync_axis: ACTIVE, FP, SYNC and BP must all be non-zero");
   end

   // primed is clear after reset: the first step presents position 0 rather
   // than 1, so the first enabled pixel after reset is the frame origin.
   logic             primed;
   logic [CNT_W-1:0] count_nxt;

   // The >= catches an out-of-range count (e.g. after an upset) and folds it
   // back to 0 on the next step, same as a normal wrap.
   assign wrap = !primed || (count >= LAST);

   always_comb begin
      count_nxt = wrap ? '0 : count + 1'b1;
   end

   // NOTE: state is updated with non-blocking assignments so every flop in
   // this clock domain samples the pre-edge values of its neighbours.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         primed <= 1'b0;
         count  <= '0;
         de     <= 1'b0;
         sync   <= 1'b0;
      end else if (step) begin
         primed <= 1'b1;
         count  <= count_nxt;
         de     <= (count_nxt < ACT_END);
         sync   <= (count_nxt >= SYNC_FIRST) && (count_nxt <= SYNC_LAST);
      end
   end

endmodule

// File: rtl/tft_timing_gen.sv
// ---------------------------------------------------------------------------
// tft_timing_gen
//   Raster timing for the TFT-LCD path: pixel/line counters, Hsync/Vsync,
//   hDE/vDE/DE and line/frame strobes. Advances one pixel per CLK in which
//   PIX_CE is high; everything holds otherwise.
//   Ports:
//     CLK          in   system clock
//     RESET        in   synchronous active-high reset
//     PIX_CE       in   pixel enable from the pixel-clock divider
//     H_COUNT      out  pixel index within the line
//     V_COUNT      out  line index within the frame
//     Hsync/Vsync  out  sync outputs, asserted level set by SYNC_POL
//     hDE/vDE/DE   out  active-region flags; DE = hDE & vDE
//     line_start   out  1-CLK strobe when the line restarts at pixel 0
//     frame_start  out  1-CLK strobe when the frame restarts at (0,0)
// ---------------------------------------------------------------------------
module tft_timing_gen #(
   parameter int H_ACTIVE = tft_timing_pkg::H_ACTIVE,
   parameter int H_FP     = tft_timing_pkg::H_FP,
   parameter int H_SYNC   = tft_timing_pkg::H_SYNC,
   parameter int H_BP     = tft_timing_pkg::H_BP,
   parameter int V_ACTIVE = tft_timing_pkg::V_ACTIVE,
   parameter int V_FP     = tft_timing_pkg::V_FP,
   parameter int V_SYNC   = tft_timing_pkg::V_SYNC,
   parameter int V_BP     = tft_timing_pkg::V_BP,
   parameter bit SYNC_POL = tft_timing_pkg::SYNC_ACTIVE_LOW,
   parameter int CNT_W    = tft_timing_pkg::TFT_CNT_W
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             PIX_CE,
   output logic [CNT_W-1:0] H_COUNT,
   output logic [CNT_W-1:0] V_COUNT,
   output logic             Hsync,
   output logic             Vsync,
   output logic             hDE,
   output logic             vDE,
   output logic             DE,
   output logic             line_start,
   output logic             frame_start
);
   import tft_timing_pkg::*;

   logic h_wrap, v_wrap;
   logic h_sync, v_sync;
   logic v_step;

   // The vertical axis only moves when the line wraps, so Vsync edges land
   // on the same pixel as line_start.
   assign v_step = PIX_CE & h_wrap;

   tft_sync_axis #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .CNT_W  (CNT_W)
   ) u_h_axis (
      .CLK    (CLK),
      .RESET  (RESET),
      .step   (PIX_CE),
      .count  (H_COUNT),
      .wrap   (h_wrap),
      .de     (hDE),
      .sync   (h_sync)
   );

   tft_sync_axis #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .CNT_W  (CNT_W)
   ) u_v_axis (
      .CLK    (CLK),
      .RESET  (RESET),
      .step   (v_step),
      .count  (V_COUNT),
      .wrap   (v_wrap),
      .de     (vDE),
      .sync   (v_sync)
   );

   // Raw sync flags are registered and reset to 0, so the pins sit at the
   // deasserted level through reset and never glitch when a frame is aborted.
   assign Hsync = (SYNC_POL == SYNC_ACTIVE_HIGH) ? h_sync : ~h_sync;
   assign Vsync = (SYNC_POL == SYNC_ACTIVE_HIGH) ? v_sync : ~v_sync;
   assign DE    = hDE & vDE;

   // Strobes are rewritten every cycle, so they can never stretch past one CLK.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= PIX_CE & h_wrap;
         frame_start <= PIX_CE & h_wrap & v_wrap;
      end
   end

endmodule
